cu_multicycle_gen: RTL and testbench

Parametrised multicycle control unit for the 16-bit processor. It is the next generation of the fixed control FSM. Each instruction is fetched, decoded and sequenced through the datapath: program counter, instruction register, data memory, register file, register-file input mux and ALU. Compared with the previous unit it adds:
- generic field widths;
- ready-qualified memory wait states;
- a taken jump that loads the PC;
- resumable halt and a sticky illegal-opcode fault;
- optional compare-and-branch.

---
 rtl/cu_multicycle_gen_if.sv | 41 ++++
 rtl/cu_multicycle_gen.sv | 158 +++++++++++++++
 tb/tb_cu_multicycle_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cu_multicycle_gen_if.sv
// cu_multicycle_gen_if: control-unit <-> datapath signal bundle.
// master = control unit, slave = datapath/memories.
interface cu_multicycle_gen_if #(
  parameter int REG_AW  = 4,
  parameter int IR_W    = 16,
  parameter int DADDR_W = 8,
  parameter int PC_W    = 8,
  parameter int ALU_S_W = 4
);
  logic [IR_W-1:0]    IR;
  logic               I_RDY;
  logic               D_RDY;
  logic               ALU_Z;
  logic [PC_W-1:0]    PC;
  logic               Run;
  logic               PC_CLR;
  logic               PR_ID;
  logic               PC_IC;
  logic               PC_LD;
  logic [PC_W-1:0]    PC_D;
  logic [DADDR_W-1:0] D_ADDR;
  logic               D_WR;
  logic               RF_S;
  logic               RF_W_EN;
  logic [REG_AW-1:0]  RF_A_ADDR;
  logic [REG_AW-1:0]  RF_B_ADDR;
  logic [REG_AW-1:0]  RF_W_ADDR;
  logic [ALU_S_W-1:0] ALU_S;
  logic               Halted;
  logic               Fault;
  modport master (
    input  IR, I_RDY, D_RDY, ALU_Z, PC, Run,
    output PC_CLR, PR_ID, PC_IC, PC_LD, PC_D, D_ADDR, D_WR, RF_S, RF_W_EN,
           RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S, Halted, Fault
  );
  modport slave (
    output IR, I_RDY, D_RDY, ALU_Z, PC, Run,
    input  PC_CLR, PR_ID, PC_IC, PC_LD, PC_D, D_ADDR, D_WR, RF_S, RF_W_EN,
           RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S, Halted, Fault
  );
endinterface

// File: rtl/cu_multicycle_gen.sv
// cu_multicycle_gen: multicycle control FSM, outputs are a registered Moore decode of the next state.
// Define CU_BRANCH_EN to build BEQ/BNE (opcodes A/B); otherwise they fault.
module cu_multicycle_gen #(
  parameter int OP_W    = 4,
  parameter int REG_AW  = 4,
  parameter int IR_W    = 16,
  parameter int DADDR_W = 8,
  parameter int PC_W    = 8,
  parameter int ALU_S_W = 4
) (
  input logic Clock,
  input logic Reset_n,
  cu_multicycle_gen_if.master bus
);
  // S_RST only parks the FSM in reset so that INIT's PC_CLR shows on the first edge
  typedef enum logic [3:0] {
    S_RST, S_INIT, S_FETCH, S_DECODE, S_LOAD_A, S_LOAD_B, S_STORE, S_ALU, S_JMP, S_HALT, S_FAULT
`ifdef CU_BRANCH_EN
    , S_BR_CMP, S_BR_TAKE
`endif
  } state_t;
  typedef struct packed {
    logic               pc_clr;
    logic               pr_id;
    logic               pc_ic;
    logic               pc_ld;
    logic [PC_W-1:0]    pc_d;
    logic [DADDR_W-1:0] d_addr;
    logic               d_wr;
    logic               rf_s;
    logic               rf_w_en;
    logic [REG_AW-1:0]  rf_a_addr;
    logic [REG_AW-1:0]  rf_b_addr;
    logic [REG_AW-1:0]  rf_w_addr;
    logic [ALU_S_W-1:0] alu_s;
    logic               halted;
    logic               fault;
  } out_t;
  state_t state_q, state_d;
  out_t out_q, out_d;
  logic [OP_W-1:0] op;
  logic [REG_AW-1:0] ra, rb, rd;
  logic [ALU_S_W-1:0] alu_fn;
  assign op = bus.IR[IR_W-1 -: OP_W];
  assign ra = bus.IR[IR_W-OP_W-1 -: REG_AW];
  assign rb = bus.IR[IR_W-OP_W-REG_AW-1 -: REG_AW];
  assign rd = bus.IR[REG_AW-1:0];
  assign alu_fn = op == OP_W'(3) ? ALU_S_W'(1) :
                  op == OP_W'(4) ? ALU_S_W'(2) :
                  op == OP_W'(7) ? ALU_S_W'(3) :
                  op == OP_W'(8) ? ALU_S_W'(4) :
                  op == OP_W'(9) ? ALU_S_W'(5) : '0;
`ifdef CU_BRANCH_EN
  logic take;
  assign take = (op == OP_W'(10) && bus.ALU_Z) || (op == OP_W'(11) && !bus.ALU_Z);
`else
  logic unused_ok;
  assign unused_ok = ^{bus.ALU_Z, bus.PC};
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_INIT;
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = bus.I_RDY ? S_DECODE : S_FETCH;
      S_DECODE:
        case (op)
          OP_W'(0): state_d = S_FETCH;
          OP_W'(1): state_d = S_STORE;
          OP_W'(2): state_d = S_LOAD_A;
          OP_W'(3), OP_W'(4), OP_W'(7), OP_W'(8), OP_W'(9): state_d = S_ALU;
          OP_W'(5): state_d = S_HALT;
          OP_W'(6): state_d = S_JMP;
`ifdef CU_BRANCH_EN
          OP_W'(10), OP_W'(11): state_d = S_BR_CMP;
`endif
          default:  state_d = S_FAULT;
        endcase
      S_LOAD_A: state_d = bus.D_RDY ? S_LOAD_B : S_LOAD_A;
      S_STORE:  state_d = bus.D_RDY ? S_FETCH : S_STORE;
      S_LOAD_B, S_ALU, S_JMP: state_d = S_FETCH;
      S_HALT:   state_d = bus.Run ? S_FETCH : S_HALT;
      S_FAULT:  state_d = S_FAULT;
`ifdef CU_BRANCH_EN
      S_BR_CMP: state_d = take ? S_BR_TAKE : S_FETCH;
      S_BR_TAKE: state_d = S_FETCH;
`endif
      default:  state_d = S_FAULT;
    endcase
    out_d = '0;
    case (state_d)
      S_INIT:   out_d.pc_clr = 1'b1;
      S_FETCH:  out_d.pr_id = 1'b1;
      S_DECODE: out_d.pc_ic = 1'b1;
      S_LOAD_A, S_LOAD_B: begin
        out_d.d_addr    = {ra, rb};
        out_d.rf_s      = 1'b1;
        out_d.rf_w_addr = rd;
        out_d.rf_w_en   = state_d == S_LOAD_B;
      end
      S_STORE: begin
        out_d.d_addr    = {rb, rd};
        out_d.rf_a_addr = ra;
        out_d.d_wr      = 1'b1;
      end
      S_ALU: begin
        out_d.rf_a_addr = ra;
        out_d.rf_b_addr = rb;
        out_d.rf_w_addr = rd;
        out_d.rf_w_en   = 1'b1;
        out_d.alu_s     = alu_fn;
      end
      S_JMP: begin
        out_d.pc_ld = 1'b1;
        out_d.pc_d  = bus.IR[PC_W-1:0];
      end
      S_HALT:   out_d.halted = 1'b1;
      S_FAULT:  out_d.fault = 1'b1;
`ifdef CU_BRANCH_EN
      S_BR_CMP: begin
        out_d.rf_a_addr = ra;
        out_d.rf_b_addr = rb;
        out_d.alu_s     = ALU_S_W'(2);
      end
      // PC here is already incremented, so the offset is relative to the next instruction
      S_BR_TAKE: begin
        out_d.pc_ld = 1'b1;
        out_d.pc_d  = bus.PC + {{(PC_W-REG_AW){rd[REG_AW-1]}}, rd};
      end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_RST;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end
  assign bus.PC_CLR    = out_q.pc_clr;
  assign bus.PR_ID     = out_q.pr_id;
  assign bus.PC_IC     = out_q.pc_ic;
  assign bus.PC_LD     = out_q.pc_ld;
  assign bus.PC_D      = out_q.pc_d;
  assign bus.D_ADDR    = out_q.d_addr;
  assign bus.D_WR      = out_q.d_wr;
  assign bus.RF_S      = out_q.rf_s;
  assign bus.RF_W_EN   = out_q.rf_w_en;
  assign bus.RF_A_ADDR = out_q.rf_a_addr;
  assign bus.RF_B_ADDR = out_q.rf_b_addr;
  assign bus.RF_W_ADDR = out_q.rf_w_addr;
  assign bus.ALU_S     = out_q.alu_s;
  assign bus.Halted    = out_q.halted;
  assign bus.Fault     = out_q.fault;
endmodule

// File: tb/tb_cu_multicycle_gen.sv
// tb_cu_multicycle_gen: vector table plus hand sequences; expected outputs queued per cycle and compared after each edge.
module tb_cu_multicycle_gen;
  typedef struct packed {
    logic       pc_clr;
    logic       pr_id;
    logic       pc_ic;
    logic       pc_ld;
    logic [7:0] pc_d;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic       rf_w_en;
    logic [3:0] rf_a;
    logic [3:0] rf_b;
    logic [3:0] rf_w;
    logic [3:0] alu_s;
    logic       halted;
    logic       fault;
  } out_t;
  typedef struct packed {
    logic [15:0] ir;
    logic        i_rdy;
    logic        d_rdy;
    logic        alu_z;
    logic        run;
    logic [7:0]  pc;
    out_t        exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_pass = 0;
  vec_t tbl[$];
  out_t sb[$];
  out_t act;
  cu_multicycle_gen_if bus ();
  cu_multicycle_gen dut (.Clock(clk), .Reset_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  assign act = {bus.PC_CLR, bus.PR_ID, bus.PC_IC, bus.PC_LD, bus.PC_D, bus.D_ADDR, bus.D_WR,
                bus.RF_S, bus.RF_W_EN, bus.RF_A_ADDR, bus.RF_B_ADDR, bus.RF_W_ADDR, bus.ALU_S,
                bus.Halted, bus.Fault};
  function automatic out_t o_init();
    out_t o = '0; o.pc_clr = 1'b1; return o;
  endfunction
  function automatic out_t o_fetch();
    out_t o = '0; o.pr_id = 1'b1; return o;
  endfunction
  function automatic out_t o_dec();
    out_t o = '0; o.pc_ic = 1'b1; return o;
  endfunction
  function automatic out_t o_alu(input logic [3:0] a, b, w, s);
    out_t o = '0; o.rf_a = a; o.rf_b = b; o.rf_w = w; o.rf_w_en = 1'b1; o.alu_s = s; return o;
  endfunction
  function automatic out_t o_ld(input logic [7:0] ad, input logic [3:0] w, input logic we);
    out_t o = '0; o.d_addr = ad; o.rf_s = 1'b1; o.rf_w = w; o.rf_w_en = we; return o;
  endfunction
  function automatic out_t o_st(input logic [7:0] ad, input logic [3:0] a);
    out_t o = '0; o.d_addr = ad; o.rf_a = a; o.d_wr = 1'b1; return o;
  endfunction
  function automatic out_t o_pcld(input logic [7:0] d);
    out_t o = '0; o.pc_ld = 1'b1; o.pc_d = d; return o;
  endfunction
  function automatic out_t o_cmp(input logic [3:0] a, b);
    out_t o = '0; o.rf_a = a; o.rf_b = b; o.alu_s = 4'd2; return o;
  endfunction
  function automatic out_t o_halt();
    out_t o = '0; o.halted = 1'b1; return o;
  endfunction
  function automatic out_t o_fault();
    out_t o = '0; o.fault = 1'b1; return o;
  endfunction
  task automatic check(input string nm, input out_t got, input out_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask
  task automatic add(input logic [15:0] ir, input logic i, d, z, r, input logic [7:0] pc, input out_t e);
    tbl.push_back('{ir, i, d, z, r, pc, e});
  endtask
  task automatic step(input logic [15:0] ir, input logic i, d, z, r, input logic [7:0] pc,
                      input out_t e, input string nm);
    bus.IR = ir; bus.I_RDY = i; bus.D_RDY = d; bus.ALU_Z = z; bus.Run = r; bus.PC = pc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty", nm);
    end else check(nm, act, sb.pop_front());
  endtask
  initial begin
    logic [15:0] alu_ir [4] = '{16'h4567, 16'h7ABC, 16'h8123, 16'h9FED};
    logic [15:0] alu_ex [4] = '{16'h5672, 16'hABC3, 16'h1234, 16'hFED5};
    logic [15:0] x;
    add(16'h3123, 1, 1, 0, 0, 8'h00, o_init());
    add(16'h3123, 1, 1, 0, 0, 8'h00, o_fetch());
    add(16'h3123, 1, 1, 0, 0, 8'h00, o_dec());
    add(16'h3123, 1, 1, 0, 0, 8'h00, o_alu(4'h1, 4'h2, 4'h3, 4'h1));
    add(16'h2A53, 0, 1, 0, 1, 8'h00, o_fetch());
    add(16'h2A53, 0, 0, 0, 1, 8'h00, o_fetch());
    add(16'h2A53, 1, 0, 0, 0, 8'h00, o_dec());
    add(16'h2A53, 1, 0, 0, 0, 8'h00, o_ld(8'hA5, 4'h3, 1'b0));
    for (int k = 0; k < 3; k++) add(16'h2A53, 1, 0, 0, 0, 8'h00, o_ld(8'hA5, 4'h3, 1'b0));
    add(16'h2A53, 1, 1, 0, 0, 8'h00, o_ld(8'hA5, 4'h3, 1'b1));
    add(16'h2A53, 1, 1, 0, 0, 8'h00, o_fetch());
    add(16'h13C5, 1, 0, 0, 0, 8'h00, o_dec());
    add(16'h13C5, 1, 0, 0, 0, 8'h00, o_st(8'hC5, 4'h3));
    add(16'h13C5, 1, 0, 0, 0, 8'h00, o_st(8'hC5, 4'h3));
    add(16'h13C5, 1, 1, 0, 0, 8'h00, o_fetch());
    add(16'h6042, 1, 1, 0, 0, 8'h00, o_dec());
    add(16'h6042, 1, 1, 0, 0, 8'h00, o_pcld(8'h42));
    add(16'h6042, 1, 1, 0, 0, 8'h00, o_fetch());
    for (int k = 0; k < 4; k++) begin
      x = alu_ex[k];
      add(alu_ir[k], 1, 1, 0, 0, 8'h00, o_dec());
      add(alu_ir[k], 1, 1, 0, 0, 8'h00, o_alu(x[15:12], x[11:8], x[7:4], x[3:0]));
      add(alu_ir[k], 1, 1, 0, 0, 8'h00, o_fetch());
    end
    add(16'h0FFF, 1, 1, 0, 0, 8'h00, o_dec());
    add(16'h0FFF, 1, 1, 0, 0, 8'h00, o_fetch());
`ifdef CU_BRANCH_EN
    add(16'hA12E, 1, 1, 1, 0, 8'h10, o_dec());
    add(16'hA12E, 1, 1, 1, 0, 8'h10, o_cmp(4'h1, 4'h2));
    add(16'hA12E, 1, 1, 1, 0, 8'h10, o_pcld(8'h0E));
    add(16'hA12E, 1, 1, 1, 0, 8'h10, o_fetch());
    add(16'hA12E, 1, 1, 0, 0, 8'h10, o_dec());
    add(16'hA12E, 1, 1, 0, 0, 8'h10, o_cmp(4'h1, 4'h2));
    add(16'hA12E, 1, 1, 0, 0, 8'h10, o_fetch());
    add(16'hB34F, 1, 1, 0, 0, 8'h00, o_dec());
    add(16'hB34F, 1, 1, 0, 0, 8'h00, o_cmp(4'h3, 4'h4));
    add(16'hB34F, 1, 1, 0, 0, 8'h00, o_pcld(8'hFF));
    add(16'hB34F, 1, 1, 0, 0, 8'h00, o_fetch());
    add(16'hB347, 1, 1, 0, 0, 8'h20, o_dec());
    add(16'hB347, 1, 1, 0, 0, 8'h20, o_cmp(4'h3, 4'h4));
    add(16'hB347, 1, 1, 0, 0, 8'h20, o_pcld(8'h27));
    add(16'hB347, 1, 1, 0, 0, 8'h20, o_fetch());
    add(16'hB347, 1, 1, 1, 0, 8'h20, o_dec());
    add(16'hB347, 1, 1, 1, 0, 8'h20, o_cmp(4'h3, 4'h4));
    add(16'hB347, 1, 1, 1, 0, 8'h20, o_fetch());
`endif
    rst_n = 1'b0;
    bus.IR = '0; bus.I_RDY = 1'b0; bus.D_RDY = 1'b0; bus.ALU_Z = 1'b0; bus.Run = 1'b0; bus.PC = '0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", act, '0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < tbl.size(); k++)
      step(tbl[k].ir, tbl[k].i_rdy, tbl[k].d_rdy, tbl[k].alu_z, tbl[k].run, tbl[k].pc, tbl[k].exp,
           $sformatf("vec%0d", k));
    step(16'h5000, 1, 1, 0, 0, 8'h00, o_dec(), "halt_decode");
    step(16'h5000, 1, 1, 0, 1, 8'h00, o_halt(), "halt_enter_with_run");
    for (int k = 0; k < 10; k++) step(16'h5000, 1, 1, 0, 0, 8'h00, o_halt(), $sformatf("halt_hold%0d", k));
    step(16'h5000, 1, 1, 0, 1, 8'h00, o_fetch(), "halt_resume");
    step(16'hF000, 1, 1, 0, 0, 8'h00, o_dec(), "illegal_decode");
    step(16'hF000, 1, 1, 0, 0, 8'h00, o_fault(), "illegal_fault");
    for (int k = 0; k < 3; k++) step(16'h0000, 1, 1, 0, 1, 8'h00, o_fault(), $sformatf("fault_sticky%0d", k));
    #2 rst_n = 1'b0;
    #1 check("reset_async_from_fault", act, '0);
    @(negedge clk) rst_n = 1'b1;
    step(16'h13C5, 1, 0, 0, 0, 8'h00, o_init(), "rst2_init");
    step(16'h13C5, 1, 0, 0, 0, 8'h00, o_fetch(), "rst2_fetch");
    step(16'h13C5, 1, 0, 0, 0, 8'h00, o_dec(), "rst2_decode");
    step(16'h13C5, 1, 0, 0, 0, 8'h00, o_st(8'hC5, 4'h3), "store_wait0");
    step(16'h13C5, 1, 0, 0, 0, 8'h00, o_st(8'hC5, 4'h3), "store_wait1");
    #2 rst_n = 1'b0;
    #1 check("reset_mid_store", act, '0);
    @(posedge clk);
    #1 check("reset_mid_store_hold", act, '0);
    @(negedge clk) rst_n = 1'b1;
    step(16'hA12E, 1, 1, 1, 0, 8'h10, o_init(), "rst3_init");
    step(16'hA12E, 1, 1, 1, 0, 8'h10, o_fetch(), "rst3_fetch");
`ifndef CU_BRANCH_EN
    step(16'hA12E, 1, 1, 1, 0, 8'h10, o_dec(), "nobr_decode");
    for (int k = 0; k < 4; k++) step(16'hA12E, 1, 1, 1, 1, 8'h10, o_fault(), $sformatf("nobr_fault%0d", k));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
